mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator-side controller for the 64-bit data memory (Memoria64).
- Takes RISC-V load/store requests (byte/half/word/double) and drives the memory's read address, write address, data and write-enable ports.
- The memory only stores whole 64-bit words. Sub-doubleword stores are therefore done as read-modify-write.
- Returns sign- or zero-extended load data to the core with a single-cycle response pulse.

Parameters:
- RD_LATENCY, 1: number of Clk edges between mem_raddress changing and mem_dataout reflecting it. 0 means a combinational read.
- ADDR_W, 64: width of byte address and memory address buses.

Ports:
- Clk  input  1  clock, rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = B, 01 = H, 10 = W, 11 = D.
- req_unsigned  input  1  zero-extend load result (LBU/LHU/LWU).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  64  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned access; valid with rsp_valid.
- mem_raddress  output  ADDR_W  to Memoria64 raddress.
- mem_waddress  output  ADDR_W  to Memoria64 waddress.
- mem_datain  output  64  to Memoria64 Datain.
- mem_dataout  input  64  from Memoria64 Dataout.
- mem_wr  output  1  to Memoria64 Wr.

Behaviour:
- Reset (Reset_n low, async):
  - state = IDLE; req_ready = 1.
  - rsp_valid, rsp_err, mem_wr = 0.
  - rsp_rdata, mem_raddress, mem_waddress, mem_datain = 0.
- States: IDLE, RD_WAIT, WRITE, RESP.
- Acceptance: req_valid & req_ready at a rising edge (E0). The edge registers:
  - aligned address A = {req_addr[ADDR_W-1:3], 3'b000}, driven on both mem_raddress and mem_waddress;
  - lane = req_addr[2:0];
  - size, we, unsigned, wdata.
- Misalignment: addr mod (1 << size) != 0.
  - IDLE -> RESP; rsp_err = 1, rsp_rdata = 0.
  - No mem_wr assertion.
- Load:
  - IDLE -> RD_WAIT for RD_LATENCY+1 cycles.
  - mem_dataout sampled at edge E(RD_LATENCY+1).
  - Field = dataout >> (8*lane), truncated to the access size, then sign-extended (or zero-extended if unsigned; D is never extended).
  - -> RESP.
- Store D:
  - IDLE -> WRITE.
  - mem_wr = 1 and mem_datain = wdata for exactly one cycle; write commits at E1.
  - -> RESP at E1.
- Store B/H/W:
  - IDLE -> RD_WAIT (RD_LATENCY+1 cycles), sample old word.
  - mem_datain = old word with bytes [lane .. lane+bytes-1] replaced by wdata low bytes, little-endian.
  - -> WRITE (one cycle, mem_wr = 1) -> RESP.
- RESP: one cycle with rsp_valid = 1, then -> IDLE. There is no response backpressure.
- Response timing, counted from E0:
  - error: rsp_valid high E0..E1;
  - D store: rsp_valid high E1..E2;
  - load: rsp_valid high E(L+1)..E(L+2);
  - sub-D store: rsp_valid high E(L+2)..E(L+3);
  - where L = RD_LATENCY.
- req_ready = (state == IDLE). Back-to-back: a new request can be accepted at the edge ending RESP+IDLE, i.e. one idle cycle minimum between responses.
- mem_wr is combinational from state == WRITE. It is never high outside WRITE.
- Reset mid-operation:
  - abort immediately; mem_wr drops asynchronously;
  - no response is issued; any uncommitted write is lost.
- rsp_rdata and rsp_err hold their value after RESP until the next response. They are only meaningful when rsp_valid = 1.

Test Plan:
- Reset with req_valid = 1 -> all outputs 0, req_ready = 1, no mem_wr for 5 cycles after release while req_valid = 0.
- Memory[0x10] = 0x8877665544332211; LB addr 0x17 signed -> rsp_rdata = 0xFFFFFFFFFFFFFF88; LBU same addr -> 0x88; LW 0x14 -> 0xFFFFFFFF88776655; rsp_valid exactly at E2 for RD_LATENCY = 1.
- SD 0x20 data 0xFFFFFFFFFFFFFFFF -> mem_wr high one cycle, mem_waddress = 0x20, rsp_valid at E1, memory[0x20] = all ones.
- Memory[0x20] = 0; SH addr 0x22 data 0x1234ABCD -> memory[0x20] = 0x00000000ABCD0000, exactly one mem_wr cycle, rsp_valid at E3.
- LW addr 0x21 -> rsp_err = 1, rsp_valid at E0..E1, mem_wr never asserted, memory unchanged.
- Assert Reset_n low during WRITE of a SB -> mem_wr falls without a clock edge, no rsp_valid, memory unchanged, next request served normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store front end for a 64-bit word memory; sub-doubleword stores are read-modify-write.
// Latency: err 0, SD 1, load L+1, sub-D store L+2 cycles to rsp_valid; one request in flight, no response backpressure.
`timescale 1ns/1ps
module mem_access_ctrl #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_raddress,
    output logic [ADDR_W-1:0] mem_waddress,
    output logic [63:0]       mem_datain,
    input  logic [63:0]       mem_dataout,
    output logic              mem_wr
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;
    localparam int CW = $clog2(RD_LATENCY + 2);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     lane;
    logic [1:0]     size;
    logic           we, uns;
    logic [63:0]    wdata;
    logic           accept, misaligned, sample;
    logic [5:0]     sh;
    logic [63:0]    field, load_val, size_mask, merged;

    assign accept = req_valid && (state == IDLE);
    assign sample = (state == RD_WAIT) && (cnt == CW'(RD_LATENCY));
    assign sh     = {lane, 3'b000};
    assign field  = mem_dataout >> sh;

    always_comb begin
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    always_comb begin
        load_val  = field;
        size_mask = '1;
        case (size)
            2'd0: begin
                size_mask = 64'h0000_0000_0000_00FF;
                load_val  = {{56{field[7] & ~uns}}, field[7:0]};
            end
            2'd1: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                load_val  = {{48{field[15] & ~uns}}, field[15:0]};
            end
            2'd2: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                load_val  = {{32{field[31] & ~uns}}, field[31:0]};
            end
            default: begin
                size_mask = '1;
                load_val  = field;
            end
        endcase
    end

    // Little-endian byte-lane merge of store data into the old word.
    assign merged = (mem_dataout & ~(size_mask << sh)) | ((wdata & size_mask) << sh);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)                       state_nxt = RESP;
                    else if (req_we && req_size == 2'd3)  state_nxt = WRITE;
                    else                                  state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: if (sample) state_nxt = we ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        mem_wr    = (state == WRITE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt          <= '0;
            lane         <= '0;
            size         <= '0;
            we           <= 1'b0;
            uns          <= 1'b0;
            wdata        <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            mem_raddress <= '0;
            mem_waddress <= '0;
            mem_datain   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_raddress <= {req_addr[ADDR_W-1:3], 3'b000};
                        mem_waddress <= {req_addr[ADDR_W-1:3], 3'b000};
                        lane         <= req_addr[2:0];
                        size         <= req_size;
                        we           <= req_we;
                        uns          <= req_unsigned;
                        wdata        <= req_wdata;
                        mem_datain   <= req_wdata;
                        cnt          <= '0;
                        if (misaligned) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (sample) begin
                        if (we) begin
                            mem_datain <= merged;
                        end else begin
                            rsp_rdata <= load_val;
                            rsp_err   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WRITE: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl against a 1-cycle-latency 64-bit word memory model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mem_wr;
    logic [63:0] rsp_rdata, mem_raddress, mem_waddress, mem_datain, mem_dataout;

    logic [63:0] mem [0:31];
    logic        bd_we;
    logic [4:0]  bd_idx;
    logic [63:0] bd_dat;

    int          checks = 0;
    int          errors = 0;
    int          rk, nwr, cnt;
    logic [63:0] rd, wa;
    logic        re;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.RD_LATENCY(1), .ADDR_W(64)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_raddress(mem_raddress), .mem_waddress(mem_waddress),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout), .mem_wr(mem_wr)
    );

    // Memory model: registered read (latency 1), write on the edge while Wr is high.
    always @(posedge Clk) begin
        if (mem_wr)     mem[mem_waddress[7:3]] <= mem_datain;
        else if (bd_we) mem[bd_idx] <= bd_dat;
        mem_dataout <= mem[mem_raddress[7:3]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] idx, input logic [63:0] dat);
        bd_idx = idx;
        bd_dat = dat;
        bd_we  = 1'b1;
        @(posedge Clk); #1;
        bd_we  = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic un,
                         input logic [63:0] a, input logic [63:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge Clk); #1;
        req_valid    = 1'b0;
    endtask

    // Window k spans E(k)..E(k+1) measured from the acceptance edge E0.
    task automatic run(input logic we, input logic [1:0] sz, input logic un,
                       input logic [63:0] a, input logic [63:0] wd,
                       output int k_rsp, output logic [63:0] rdat, output logic rerr,
                       output int n_wr, output logic [63:0] waddr);
        drive(we, sz, un, a, wd);
        k_rsp = -1; rdat = '0; rerr = 1'b0; n_wr = 0; waddr = '0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) begin
                k_rsp = (k_rsp < 0) ? k : 100;
                rdat  = rsp_rdata;
                rerr  = rsp_err;
            end
            if (mem_wr) begin
                n_wr++;
                waddr = mem_waddress;
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        Reset_n = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_dat = '0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h18; req_wdata = 64'h55;
        #12;
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_raddr", mem_raddress, 64'd0);
        chk("rst_waddr", mem_waddress, 64'd0);
        chk("rst_datain", mem_datain, 64'd0);
        req_valid = 1'b0;
        Reset_n   = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            if (mem_wr || !req_ready) cnt++;
        end
        chk("idle_after_rst", 64'(cnt), 64'd0);

        poke(5'd2, 64'h8877665544332211);
        run(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, rk, rd, re, nwr, wa);
        chk("lb_data", rd, 64'hFFFFFFFFFFFFFF88);
        chk("lb_timing", 64'(rk), 64'd2);
        chk("lb_err", {63'd0, re}, 64'd0);
        chk("lb_nwr", 64'(nwr), 64'd0);
        run(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, rk, rd, re, nwr, wa);
        chk("lbu_data", rd, 64'h88);
        run(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, rk, rd, re, nwr, wa);
        chk("lw_data", rd, 64'hFFFFFFFF88776655);
        chk("lw_timing", 64'(rk), 64'd2);
        run(1'b0, 2'd1, 1'b1, 64'h12, 64'd0, rk, rd, re, nwr, wa);
        chk("lhu_data", rd, 64'h4433);
        run(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rk, rd, re, nwr, wa);
        chk("ld_data", rd, 64'h8877665544332211);

        run(1'b1, 2'd3, 1'b0, 64'h20, 64'hFFFFFFFFFFFFFFFF, rk, rd, re, nwr, wa);
        chk("sd_nwr", 64'(nwr), 64'd1);
        chk("sd_waddr", wa, 64'h20);
        chk("sd_timing", 64'(rk), 64'd1);
        chk("sd_rdata", rd, 64'd0);
        chk("sd_mem", mem[4], 64'hFFFFFFFFFFFFFFFF);

        poke(5'd4, 64'd0);
        run(1'b1, 2'd1, 1'b0, 64'h22, 64'h1234ABCD, rk, rd, re, nwr, wa);
        chk("sh_mem", mem[4], 64'h00000000ABCD0000);
        chk("sh_nwr", 64'(nwr), 64'd1);
        chk("sh_timing", 64'(rk), 64'd3);
        run(1'b1, 2'd2, 1'b0, 64'h24, 64'hDEADBEEF, rk, rd, re, nwr, wa);
        chk("sw_mem", mem[4], 64'hDEADBEEFABCD0000);
        chk("sw_timing", 64'(rk), 64'd3);

        run(1'b0, 2'd2, 1'b0, 64'h21, 64'd0, rk, rd, re, nwr, wa);
        chk("mis_err", {63'd0, re}, 64'd1);
        chk("mis_timing", 64'(rk), 64'd0);
        chk("mis_nwr", 64'(nwr), 64'd0);
        chk("mis_rdata", rd, 64'd0);
        chk("mis_mem", mem[4], 64'hDEADBEEFABCD0000);

        poke(5'd6, 64'h1111111111111111);
        drive(1'b1, 2'd0, 1'b0, 64'h33, 64'hAA);
        @(posedge Clk);
        @(posedge Clk); #1;
        chk("sb_wr_before_rst", {63'd0, mem_wr}, 64'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("sb_wr_async_drop", {63'd0, mem_wr}, 64'd0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            if (rsp_valid || mem_wr) cnt++;
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            if (rsp_valid || mem_wr) cnt++;
        end
        chk("sb_rst_no_rsp", 64'(cnt), 64'd0);
        chk("sb_rst_mem", mem[6], 64'h1111111111111111);
        run(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rk, rd, re, nwr, wa);
        chk("post_rst_ld", rd, 64'h8877665544332211);
        chk("post_rst_timing", 64'(rk), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
